reg_share_arbiter: RTL

REG_SHARE_ARBITER -- requirements
Module: reg_share_arbiter

---
 rtl/reg_share_arbiter_if.sv | 32 +++
 rtl/reg_share_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/reg_share_arbiter_if.sv
// rtl/reg_share_arbiter_if.sv - request/write bus between requesters and the shared-register arbiter
//
// Purpose: bundles the four-requester access bus of reg_share_arbiter.
// Ports (as seen from the arbiter, modport slave):
//   req      in   4         per-requester access request
//   wr_en    in   4         per-requester write strobe
//   wr_data  in   4*WIDTH   packed write data, requester i at [i*WIDTH +: WIDTH]
//   gnt      out  4         registered one-hot (or zero) grant
//   q        out  WIDTH     shared register contents
//   busy     out  1         any grant active
//   timeout  out  1         one-cycle pulse after a forced release
interface reg_share_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [3:0]         req;
    logic [3:0]         wr_en;
    logic [4*WIDTH-1:0] wr_data;
    logic [3:0]         gnt;
    logic [WIDTH-1:0]   q;
    logic               busy;
    logic               timeout;

    modport master (
        output req, wr_en, wr_data,
        input  gnt, q, busy, timeout
    );

    modport slave (
        input  req, wr_en, wr_data,
        output gnt, q, busy, timeout
    );
endinterface

// File: rtl/reg_share_arbiter.sv
// rtl/reg_share_arbiter.sv - round-robin arbiter guarding one shared register
//
// Purpose: four requesters share a WIDTH-bit register. One owner at a time is
// granted; only the owner's write strobe can load the register. Under
// contention an owner is forced off after MAX_HOLD grant cycles.
// Ports:
//   clk    in  1   rising-edge clock
//   reset  in  1   synchronous active-high reset
//   bus    slave modport of reg_share_arbiter_if (req, wr_en, wr_data in;
//          gnt, q, busy, timeout out)
module reg_share_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    reg_share_arbiter_if.slave   bus
);
    localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       owner_q, owner_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       gnt_q, gnt_d;
    logic             timeout_q, timeout_d;
    logic [WIDTH-1:0] q_q, q_d;

    logic             pick_valid;
    logic [1:0]       pick_idx;
    logic [1:0]       scan_idx;
    logic             others_req;

    // Rotating-priority scan starting at ptr: first set req bit wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = ptr_q;
        scan_idx   = ptr_q;
        for (int k = 0; k < 4; k++) begin
            scan_idx = ptr_q + 2'(k);
            if (!pick_valid && bus.req[scan_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    assign others_req = |(bus.req & ~(4'b0001 << owner_q));

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                gnt_d = 4'b0000;
                if (pick_valid) begin
                    owner_d = pick_idx;
                    gnt_d   = 4'b0001 << pick_idx;
                    cnt_d   = 4'd1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!bus.req[owner_q]) begin
                    // Voluntary release: owner drops to lowest priority.
                    gnt_d   = 4'b0000;
                    ptr_d   = owner_q + 2'd1;
                    state_d = IDLE;
                end else if (cnt_q < MAX_HOLD_C) begin
                    cnt_d = cnt_q + 4'd1;
                end else if (others_req) begin
                    // Forced release: hold budget spent and someone is waiting.
                    gnt_d     = 4'b0000;
                    timeout_d = 1'b1;
                    ptr_d     = owner_q + 2'd1;
                    state_d   = IDLE;
                end
                // Otherwise sole requester keeps the grant; cnt stays saturated.
            end
            default: state_d = IDLE;
        endcase
    end

    // The write is qualified by the registered grant, so a write coinciding
    // with the release edge still lands.
    always_comb begin
        q_d = q_q;
        if (gnt_q[owner_q] && bus.wr_en[owner_q]) begin
            q_d = bus.wr_data[int'(owner_q)*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            owner_q   <= 2'd0;
            cnt_q     <= 4'd0;
            gnt_q     <= 4'b0000;
            timeout_q <= 1'b0;
            q_q       <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            timeout_q <= timeout_d;
            q_q       <= q_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.q       = q_q;
    assign bus.busy    = |gnt_q;
    assign bus.timeout = timeout_q;
endmodule
